// File: rtl/stream_width_packer_if.sv
// Handshake bundle for the width packer: narrow beat input with last flag,
// wide word output with per-lane keep and last flag.
interface stream_width_packer_if #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
);
    logic [IN_WIDTH-1:0]       s_data_i;
    logic                      s_valid_i;
    logic                      s_last_i;
    logic                      s_ready_o;
    logic [IN_WIDTH*RATIO-1:0] m_data_o;
    logic [RATIO-1:0]          m_keep_o;
    logic                      m_last_o;
    logic                      m_valid_o;
    logic                      m_ready_i;

    // Environment side: drives beats and downstream ready, observes words.
    modport master (
        output s_data_i, s_valid_i, s_last_i, m_ready_i,
        input  s_ready_o, m_data_o, m_keep_o, m_last_o, m_valid_o
    );

    // Packer side.
    modport slave (
        input  s_data_i, s_valid_i, s_last_i, m_ready_i,
        output s_ready_o, m_data_o, m_keep_o, m_last_o, m_valid_o
    );
endinterface

// File: rtl/stream_width_packer.sv
// Packs RATIO narrow beats (or a shorter packet tail) into one wide word with
// contiguous keep bits, held in a single-entry output register. Counts packets
// whose last word has been handed downstream.
module stream_width_packer #(
    parameter int IN_WIDTH  = 8,
    parameter int RATIO     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    stream_width_packer_if.slave bus,
    output logic [CNT_WIDTH-1:0] pkt_cnt_o
);
    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int IDX_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(RATIO - 1);

    logic [OUT_WIDTH-1:0] acc_data_q, acc_data_d;
    logic [RATIO-1:0]     acc_keep_q, acc_keep_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [RATIO-1:0]     out_keep_q, out_keep_d;
    logic                 out_last_q, out_last_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

    logic                 s_ready;
    logic                 in_accept;
    logic                 out_accept;
    logic                 complete;
    logic [OUT_WIDTH-1:0] merge_data;
    logic [RATIO-1:0]     merge_keep;

    // Next-state logic: ready depends only on the output register, so a held
    // word blocks every incoming beat, completing or not.
    always_comb begin
        s_ready    = ~out_valid_q | bus.m_ready_i;
        in_accept  = bus.s_valid_i & s_ready;
        out_accept = out_valid_q & bus.m_ready_i;
        complete   = in_accept & ((idx_q == LAST_IDX) | bus.s_last_i);

        merge_data = acc_data_q;
        merge_keep = acc_keep_q;
        merge_data[idx_q*IN_WIDTH +: IN_WIDTH] = bus.s_data_i;
        merge_keep[idx_q] = 1'b1;

        acc_data_d  = acc_data_q;
        acc_keep_d  = acc_keep_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        pkt_cnt_d   = pkt_cnt_q;

        if (out_accept && !complete) begin
            out_valid_d = 1'b0;
        end

        if (complete) begin
            out_data_d  = merge_data;
            out_keep_d  = merge_keep;
            out_last_d  = bus.s_last_i;
            out_valid_d = 1'b1;
            acc_data_d  = '0;
            acc_keep_d  = '0;
            idx_d       = '0;
        end else if (in_accept) begin
            acc_data_d = merge_data;
            acc_keep_d = merge_keep;
            idx_d      = idx_q + IDX_WIDTH'(1);
        end

        if (out_accept && out_last_q) begin
            pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
        end
    end

    // State registers; reset discards any partial word and any pending output.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_data_q  <= '0;
            acc_keep_q  <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            acc_data_q  <= acc_data_d;
            acc_keep_q  <= acc_keep_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign bus.s_ready_o = s_ready;
    assign bus.m_data_o  = out_data_q;
    assign bus.m_keep_o  = out_keep_q;
    assign bus.m_last_o  = out_last_q;
    assign bus.m_valid_o = out_valid_q;
    assign pkt_cnt_o     = pkt_cnt_q;

endmodule

// File: tb/tb_stream_width_packer.sv
// Directed bench for stream_width_packer with IN_WIDTH=8, RATIO=4.
module tb_stream_width_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pkt_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    stream_width_packer_if #(.IN_WIDTH(8), .RATIO(4)) bus ();

    stream_width_packer #(.IN_WIDTH(8), .RATIO(4), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .pkt_cnt_o (pkt_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic v, input logic l);
        bus.s_data_i  = d;
        bus.s_valid_i = v;
        bus.s_last_i  = l;
        #1;
    endtask

    task automatic test_reset();
        bus.m_ready_i = 1'b1;
        drive(8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        n_checks++; if (bus.m_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.m_valid_o); end
        n_checks++; if (bus.m_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 00000000", bus.m_data_o); end
        n_checks++; if (bus.m_keep_o !== 4'h0) begin n_fail++; $display("FAIL reset_keep: got %b want 0000", bus.m_keep_o); end
        n_checks++; if (bus.m_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", bus.m_last_o); end
        n_checks++; if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", pkt_cnt); end
        n_checks++; if (bus.s_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.s_ready_o); end
    endtask

    task automatic test_full_word();
        logic [7:0] beats [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.m_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(beats[i], 1'b1, i == 3);
            n_checks++; if (bus.s_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_ready%0d: got %b want 1", i, bus.s_ready_o); end
            step();
        end
        drive(8'h00, 1'b0, 1'b0);
        n_checks++; if (bus.m_valid_o !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b want 1", bus.m_valid_o); end
        n_checks++; if (bus.m_data_o !== 32'h44332211) begin n_fail++; $display("FAIL full_data: got %h want 44332211", bus.m_data_o); end
        n_checks++; if (bus.m_keep_o !== 4'b1111) begin n_fail++; $display("FAIL full_keep: got %b want 1111", bus.m_keep_o); end
        n_checks++; if (bus.m_last_o !== 1'b1) begin n_fail++; $display("FAIL full_last: got %b want 1", bus.m_last_o); end
        n_checks++; if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL full_cnt_pre: got %0d want 0", pkt_cnt); end
        step();
        n_checks++; if (bus.m_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_valid_drop: got %b want 0", bus.m_valid_o); end
        n_checks++; if (pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL full_cnt: got %0d want 1", pkt_cnt); end
    endtask

    task automatic test_short_packet();
        drive(8'hAA, 1'b1, 1'b0); step();
        n_checks++; if (bus.m_valid_o !== 1'b0) begin n_fail++; $display("FAIL short_early: got %b want 0", bus.m_valid_o); end
        drive(8'hBB, 1'b1, 1'b1); step();
        drive(8'h00, 1'b0, 1'b0);
        n_checks++; if (bus.m_data_o !== 32'h0000BBAA) begin n_fail++; $display("FAIL short_data: got %h want 0000bbaa", bus.m_data_o); end
        n_checks++; if (bus.m_keep_o !== 4'b0011) begin n_fail++; $display("FAIL short_keep: got %b want 0011", bus.m_keep_o); end
        n_checks++; if (bus.m_last_o !== 1'b1 || bus.m_valid_o !== 1'b1) begin n_fail++; $display("FAIL short_last_valid: got %b%b want 11", bus.m_last_o, bus.m_valid_o); end
        step();
        n_checks++; if (pkt_cnt !== 16'd2) begin n_fail++; $display("FAIL short_cnt: got %0d want 2", pkt_cnt); end
    endtask

    task automatic test_six_beat();
        for (int i = 1; i <= 4; i++) begin
            drive(8'(i), 1'b1, 1'b0); step();
        end
        n_checks++; if (bus.m_data_o !== 32'h04030201 || bus.m_keep_o !== 4'b1111 || bus.m_last_o !== 1'b0 || bus.m_valid_o !== 1'b1)
            begin n_fail++; $display("FAIL six_word1: got %h/%b/%b/%b want 04030201/1111/0/1", bus.m_data_o, bus.m_keep_o, bus.m_last_o, bus.m_valid_o); end
        drive(8'h05, 1'b1, 1'b0); step();
        n_checks++; if (bus.m_valid_o !== 1'b0 || pkt_cnt !== 16'd2) begin n_fail++; $display("FAIL six_mid: got valid %b cnt %0d want 0 2", bus.m_valid_o, pkt_cnt); end
        drive(8'h06, 1'b1, 1'b1); step();
        drive(8'h00, 1'b0, 1'b0);
        n_checks++; if (bus.m_data_o !== 32'h00000605 || bus.m_keep_o !== 4'b0011 || bus.m_last_o !== 1'b1 || bus.m_valid_o !== 1'b1)
            begin n_fail++; $display("FAIL six_word2: got %h/%b/%b/%b want 00000605/0011/1/1", bus.m_data_o, bus.m_keep_o, bus.m_last_o, bus.m_valid_o); end
        step();
        n_checks++; if (pkt_cnt !== 16'd3) begin n_fail++; $display("FAIL six_cnt: got %0d want 3", pkt_cnt); end
    endtask

    task automatic test_backpressure();
        bus.m_ready_i = 1'b0;
        drive(8'h10, 1'b1, 1'b0); step();
        drive(8'h20, 1'b1, 1'b0); step();
        drive(8'h30, 1'b1, 1'b0); step();
        drive(8'h40, 1'b1, 1'b1); step();
        drive(8'h50, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.s_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d: got %b want 0", i, bus.s_ready_o); end
            n_checks++; if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== 32'h40302010 || bus.m_keep_o !== 4'b1111 || bus.m_last_o !== 1'b1)
                begin n_fail++; $display("FAIL bp_hold%0d: got %b/%h/%b/%b want 1/40302010/1111/1", i, bus.m_valid_o, bus.m_data_o, bus.m_keep_o, bus.m_last_o); end
            step();
        end
        bus.m_ready_i = 1'b1;
        #1;
        n_checks++; if (bus.s_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", bus.s_ready_o); end
        step();
        n_checks++; if (bus.m_valid_o !== 1'b0 || pkt_cnt !== 16'd4) begin n_fail++; $display("FAIL bp_handshake: got valid %b cnt %0d want 0 4", bus.m_valid_o, pkt_cnt); end
        drive(8'h60, 1'b1, 1'b1); step();
        drive(8'h00, 1'b0, 1'b0);
        n_checks++; if (bus.m_data_o !== 32'h00006050 || bus.m_keep_o !== 4'b0011 || bus.m_valid_o !== 1'b1)
            begin n_fail++; $display("FAIL bp_next_word: got %h/%b/%b want 00006050/0011/1", bus.m_data_o, bus.m_keep_o, bus.m_valid_o); end
        step();
        n_checks++; if (pkt_cnt !== 16'd5) begin n_fail++; $display("FAIL bp_cnt: got %0d want 5", pkt_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] singles [3] = '{8'h5A, 8'hA5, 8'h3C};
        bus.m_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(singles[i], 1'b1, 1'b1);
            n_checks++; if (bus.s_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b want 1", i, bus.s_ready_o); end
            step();
            n_checks++; if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== {24'h0, singles[i]} || bus.m_keep_o !== 4'b0001 || bus.m_last_o !== 1'b1)
                begin n_fail++; $display("FAIL b2b_word%0d: got %b/%h/%b/%b want 1/%h/0001/1", i, bus.m_valid_o, bus.m_data_o, bus.m_keep_o, bus.m_last_o, {24'h0, singles[i]}); end
        end
        drive(8'h00, 1'b0, 1'b0); step();
        n_checks++; if (bus.m_valid_o !== 1'b0 || pkt_cnt !== 16'd8) begin n_fail++; $display("FAIL b2b_cnt: got valid %b cnt %0d want 0 8", bus.m_valid_o, pkt_cnt); end
    endtask

    task automatic test_reset_mid_word();
        bus.m_ready_i = 1'b1;
        drive(8'h11, 1'b1, 1'b0); step();
        drive(8'h22, 1'b1, 1'b0); step();
        drive(8'h00, 1'b0, 1'b0);
        rst = 1'b1; step();
        rst = 1'b0; step();
        n_checks++; if (bus.m_valid_o !== 1'b0 || bus.m_keep_o !== 4'b0000 || pkt_cnt !== 16'd0)
            begin n_fail++; $display("FAIL rmw_after_reset: got %b/%b/%0d want 0/0000/0", bus.m_valid_o, bus.m_keep_o, pkt_cnt); end
        for (int i = 0; i < 4; i++) begin
            drive(8'((i + 1) * 8'h11), 1'b1, i == 3); step();
            if (i < 3) begin
                n_checks++; if (bus.m_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmw_early%0d: got %b want 0", i, bus.m_valid_o); end
            end
        end
        drive(8'h00, 1'b0, 1'b0);
        n_checks++; if (bus.m_data_o !== 32'h44332211 || bus.m_keep_o !== 4'b1111 || bus.m_valid_o !== 1'b1)
            begin n_fail++; $display("FAIL rmw_word: got %h/%b/%b want 44332211/1111/1", bus.m_data_o, bus.m_keep_o, bus.m_valid_o); end
        step();
        n_checks++; if (bus.m_valid_o !== 1'b0 || pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL rmw_cnt: got valid %b cnt %0d want 0 1", bus.m_valid_o, pkt_cnt); end
    endtask

    initial begin
        bus.s_data_i  = '0;
        bus.s_valid_i = 1'b0;
        bus.s_last_i  = 1'b0;
        bus.m_ready_i = 1'b1;
        test_reset();
        test_full_word();
        test_short_packet();
        test_six_beat();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
